// File: rtl/tx_pkg.sv
// Shared constants and payload types for the QPSK transmit front end.
// Sample constants are 0.7071 full scale in 12-bit two's complement.
package tx_pkg;

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned IQ_W     = 2 * SAMPLE_W;

    localparam logic [SAMPLE_W-1:0] QPSK_POS    = 12'h5A7;
    localparam logic [SAMPLE_W-1:0] QPSK_NEG    = 12'hA59;
    localparam logic [SAMPLE_W-1:0] ZERO_SAMPLE = 12'h000;

    typedef struct packed {
        logic [SAMPLE_W-1:0] i;
        logic [SAMPLE_W-1:0] q;
    } iq_sample_t;

    localparam iq_sample_t ZERO_IQ = '{i: ZERO_SAMPLE, q: ZERO_SAMPLE};

    // A 0 bit maps to the positive level, a 1 bit to the negative level.
    function automatic logic [SAMPLE_W-1:0] map_rail(input logic b);
        return b ? QPSK_NEG : QPSK_POS;
    endfunction

endpackage

// File: rtl/qpsk_mapper.sv
// Combinational QPSK mapper: one I bit and one Q bit to a packed {I,Q} sample.
module qpsk_mapper
    import tx_pkg::*;
(
    input  logic       bit_i,
    input  logic       bit_q,
    output iq_sample_t sample_c
);

    always_comb begin
        sample_c   = ZERO_IQ;
        sample_c.i = map_rail(bit_i);
        sample_c.q = map_rail(bit_q);
    end

endmodule

// File: rtl/tx_qpsk_path.sv
// QPSK symbol mapper with zero-stuffing to SPS samples per symbol, feeding an
// interpolating FIR over valid/ready handshakes on both sides.
module tx_qpsk_path
    import tx_pkg::*;
#(
    parameter int unsigned SPS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_I,
    input  logic                  in_Q,
    input  logic [7:0]            in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IQ_W-1:0]       out_data
);

    localparam int unsigned PHASE_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(SPS - 1);
    localparam logic [PHASE_W-1:0] FIRST_STUFF = (SPS > 1) ? PHASE_W'(1) : '0;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;
    logic               valid_nxt;
    iq_sample_t         data_q;
    iq_sample_t         data_nxt;
    iq_sample_t         mapped;
    logic               adv;
    logic               accept;

    // Reserved byte input is not consumed by this revision.
    logic unused_in_data;
    assign unused_in_data = ^in_data;

    qpsk_mapper u_mapper (
        .bit_i    (in_I),
        .bit_q    (in_Q),
        .sample_c (mapped)
    );

    assign adv      = !out_valid || out_ready;
    assign in_ready = rst && (phase == '0) && adv;
    assign accept   = in_valid && in_ready;
    assign out_data = data_q;

    // Next-state: stuffed zeros take priority; symbols only enter at phase 0.
    always_comb begin
        phase_nxt = phase;
        valid_nxt = out_valid;
        data_nxt  = data_q;
        if (adv) begin
            if (phase != '0) begin
                data_nxt  = ZERO_IQ;
                valid_nxt = 1'b1;
                phase_nxt = (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
            end else if (accept) begin
                data_nxt  = mapped;
                valid_nxt = 1'b1;
                phase_nxt = FIRST_STUFF;
            end else begin
                valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= '0;
            out_valid <= 1'b0;
            data_q    <= ZERO_IQ;
        end else begin
            phase     <= phase_nxt;
            out_valid <= valid_nxt;
            data_q    <= data_nxt;
        end
    end

endmodule

// File: tb/tb_tx_qpsk_path.sv
// Directed bench for tx_qpsk_path with SPS=4: reset, mapping, throughput,
// backpressure, idle gaps and reset in the middle of a group.
module tb_tx_qpsk_path;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_I;
    logic        in_Q;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;

    int vectors     = 0;
    int miscompares = 0;

    tx_qpsk_path #(.SPS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_I      (in_I),
        .in_Q      (in_Q),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] exp_iq(input logic i, input logic q);
        logic [11:0] ri;
        logic [11:0] rq;
        ri = i ? 12'hA59 : 12'h5A7;
        rq = q ? 12'hA59 : 12'h5A7;
        return {ri, rq};
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [23:0] d);
        chk({tag, "_valid"}, 24'(out_valid), 24'(v));
        chk({tag, "_data"}, out_data, d);
    endtask

    int          mp;
    int          rdy_cnt;
    logic [23:0] expd;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_I      = 1'b0;
        in_Q      = 1'b0;
        in_data   = 8'hA5;
        out_ready = 1'b1;

        // Reset held with in_valid asserted.
        for (int c = 0; c < 64; c++) begin
            tick();
            in_data = 8'($urandom);
            #1;
            chk("rst_valid", 24'(out_valid), 24'd0);
            chk("rst_data", out_data, 24'd0);
            chk("rst_ready", 24'(in_ready), 24'd0);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rel_ready", 24'(in_ready), 24'd1);
        chk("rel_valid", 24'(out_valid), 24'd0);

        // Mapping: four symbols back to back, each followed by three zeros.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_I     = 1'((k >> 1) & 1);
            in_Q     = 1'(k & 1);
            #1;
            chk("map_ready", 24'(in_ready), 24'd1);
            tick();
            in_valid = 1'b0;
            chk_out("map_sym", 1'b1, exp_iq(1'((k >> 1) & 1), 1'(k & 1)));
            chk("map_busy", 24'(in_ready), 24'd0);
            for (int s = 1; s < 4; s++) begin
                tick();
                chk_out("map_zero", 1'b1, 24'd0);
            end
        end

        // Throughput: continuous symbols with random bits.
        mp      = 0;
        rdy_cnt = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 32; c++) begin
            in_I    = 1'($urandom);
            in_Q    = 1'($urandom);
            in_data = 8'($urandom);
            #1;
            chk("thr_ready", 24'(in_ready), 24'(mp == 0));
            if (in_ready) rdy_cnt++;
            expd = (mp == 0) ? exp_iq(in_I, in_Q) : 24'd0;
            mp   = (mp + 1) % 4;
            tick();
            chk_out("thr", 1'b1, expd);
        end
        chk("thr_ready_count", 24'(rdy_cnt), 24'd8);

        // Backpressure at phase 1 holding 0x5A7A59.
        in_I = 1'b0;
        in_Q = 1'b1;
        #1;
        chk("bp_accept_ready", 24'(in_ready), 24'd1);
        tick();
        chk_out("bp_first", 1'b1, 24'h5A7A59);
        out_ready = 1'b0;
        in_I      = 1'b1;
        in_Q      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ready", 24'(in_ready), 24'd0);
            tick();
            chk_out("bp_hold", 1'b1, 24'h5A7A59);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int s = 1; s < 4; s++) begin
            tick();
            chk_out("bp_resume", 1'b1, 24'd0);
        end

        // Idle: nothing offered, output drains.
        tick();
        chk_out("idle_gap", 1'b0, 24'd0);
        chk("idle_ready", 24'(in_ready), 24'd1);

        // Single symbol, then idle, then a symbol on the last stuffed sample.
        in_valid = 1'b1;
        in_I     = 1'b1;
        in_Q     = 1'b0;
        tick();
        in_valid = 1'b0;
        chk_out("one_sym", 1'b1, 24'hA595A7);
        for (int s = 1; s < 4; s++) begin
            tick();
            chk_out("one_zero", 1'b1, 24'd0);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out("one_idle", 1'b0, 24'd0);
        end
        in_valid = 1'b1;
        in_I     = 1'b1;
        in_Q     = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_out("nb_sym", 1'b1, 24'hA59A59);
        for (int s = 1; s < 4; s++) begin
            tick();
            chk_out("nb_zero", 1'b1, 24'd0);
        end
        in_valid = 1'b1;
        in_I     = 1'b0;
        in_Q     = 1'b0;
        #1;
        chk("nb_ready", 24'(in_ready), 24'd1);
        tick();
        in_valid = 1'b0;
        chk_out("nb_next", 1'b1, 24'h5A75A7);

        // Reset mid-group after stuffed sample 2.
        tick();
        chk_out("mid_s1", 1'b1, 24'd0);
        tick();
        chk_out("mid_s2", 1'b1, 24'd0);
        rst = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 24'd0);
        chk("mid_rst_ready", 24'(in_ready), 24'd0);
        tick();
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_I     = 1'b1;
        in_Q     = 1'b0;
        #1;
        chk("mid_rel_ready", 24'(in_ready), 24'd1);
        tick();
        in_valid = 1'b0;
        chk_out("mid_sym", 1'b1, 24'hA595A7);
        for (int s = 1; s < 4; s++) begin
            tick();
            chk_out("mid_zero", 1'b1, 24'd0);
        end
        tick();
        chk_out("mid_end", 1'b0, 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_qpsk_path.md
Name: tx_qpsk_path

Overview:
- Transmit-path front end that maps one QPSK symbol (one I bit, one Q bit) to a pair of 12-bit signed baseband samples.
- Zero-stuffs each symbol up to SPS samples so that a downstream interpolating pulse-shaping FIR can consume the stream directly.
- Sits between the symbol/bit source and the FIR interpolator.
- Both sides use AXI-Stream-style valid/ready handshakes.

Parameters:
- SPS, 4, output samples per input symbol (≥1). Sample 0 carries the mapped symbol; samples 1..SPS-1 are zero.
- SAMPLE_W, 12, width of each I and Q sample (two's complement).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- in_valid  in  1  symbol valid.
- in_ready  out  1  block accepts a symbol this cycle.
- in_I  in  1  I bit of the current symbol.
- in_Q  in  1  Q bit of the current symbol.
- in_data  in  8  reserved byte-stream input; ignored by this revision.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  2*SAMPLE_W  {I[11:0], Q[11:0]}, I in the MSBs.

Behaviour:
- Mapping, per rail:
  - bit 0 → +0x5A7 (+1447 ≈ 0.7071·2048).
  - bit 1 → 0xA59 (−1447).
  - Stuffed samples are 0x000.
- State:
  - phase counter 0..SPS-1.
  - Output register: out_valid, out_data.
- Reset (rst=0, async):
  - out_valid=0, out_data=0, phase=0.
  - in_ready=0 while in reset.
- Output advance condition: adv = !out_valid || out_ready.
- in_ready = rst && phase==0 && adv. Combinational from registered state plus out_ready.
- Symbol accept (in_valid && in_ready):
  - Next edge: out_data = {map(in_I), map(in_Q)}, out_valid=1.
  - phase = 1, or stays 0 when SPS=1.
  - Latency: 1 clock from accept to out_valid.
- phase ≠ 0 and adv:
  - Next edge: out_data=0, out_valid=1.
  - phase = phase+1, wrapping to 0 after SPS-1.
  - in_valid is ignored during these phases.
- phase=0, adv, no symbol accepted: out_valid goes 0 next edge; out_data holds its value.
- Backpressure: while out_valid && !out_ready, out_data, out_valid and phase hold. in_ready=0.
- Simultaneous out_ready and a new symbol at phase 0: the current sample is consumed and the new symbol is loaded on the same edge. This gives full throughput of 1 sample/clock, i.e. 1 symbol per SPS clocks.
- Reset mid-burst: the partial zero-stuff sequence is abandoned. After release, the first accepted symbol starts a fresh SPS group.
- in_data has no effect on any output.

Decomposition:
- Package tx_pkg holds:
  - SAMPLE_W = 12.
  - QPSK_POS = 12'h5A7.
  - QPSK_NEG = 12'hA59.
  - ZERO_SAMPLE = 12'h000.
  - typedef iq_sample_t (packed {I,Q}, 24 bits).
- One sub-module, qpsk_mapper: combinational 2 bits → iq_sample_t using the package constants.
- Phase counter and output register live in the top.

Test Plan:
- Reset: hold rst=0 for 64 clocks with in_valid=1. Required: out_valid=0, out_data=0, in_ready=0 throughout; after release, in_ready=1 on the first cycle.
- Mapping, with out_ready=1, SPS=4: symbols (I,Q) = (0,0), (0,1), (1,0), (1,1). Required out_data sequence, with each group of four consecutive valid samples back to back:
  - 0x5A75A7, 0, 0, 0
  - 0x5A7A59, 0, 0, 0
  - 0xA595A7, 0, 0, 0
  - 0xA59A59, 0, 0, 0
- Throughput: in_valid=1 and out_ready=1 continuously with random bits. Required: out_valid stays 1 every cycle after the first; in_ready=1 exactly one cycle in four.
- Backpressure: deassert out_ready for 5 cycles while out_data=0x5A7A59 at phase 1. Required: out_data and out_valid hold, in_ready=0; the sequence resumes with the remaining 3 samples when out_ready returns.
- Idle: in_valid=0 after one symbol. Required: 4 valid samples, then out_valid=0 until the next symbol; a symbol arriving the same cycle the last stuffed sample is taken produces no bubble.
- Reset mid-group: assert rst after sample 2 of a group. Required: out_valid=0 asynchronously; after release the next symbol yields its mapped value first, followed by exactly 3 zeros.
